// File: rtl/seq_scan_ctrl.sv
// Frame-level controller: latches a frame and pattern on start, shifts the frame
// LSB-first through a programmable serial detector, and reports match results.
// Build option: define SEQ_NONOVERLAP_EN for non-overlapping match detection.
module seq_scan_ctrl #(
    parameter int unsigned FRAME_W = 16,
    parameter int unsigned PAT_MAX = 4,
    localparam int unsigned LEN_W = $clog2(FRAME_W + 1),
    localparam int unsigned PL_W  = $clog2(PAT_MAX + 1),
    localparam int unsigned POS_W = $clog2(FRAME_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame_data,
    input  logic [LEN_W-1:0]   frame_len,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [PL_W-1:0]    pat_len,
    output logic               busy,
    output logic               ser_bit,
    output logic               detected,
    output logic               done,
    output logic               cfg_err,
    output logic [LEN_W-1:0]   match_count,
    output logic               first_valid,
    output logic [POS_W-1:0]   first_pos
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [PAT_MAX-1:0] pat_q, pat_d;
    logic [PL_W-1:0]    pl_q, pl_d;
    logic [PAT_MAX-2:0] hist_q, hist_d;
    logic [PL_W-1:0]    seen_q, seen_d;
    logic               busy_q, busy_d;
    logic               ser_bit_q, ser_bit_d;
    logic               detected_q, detected_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;
    logic [LEN_W-1:0]   match_count_q, match_count_d;
    logic               first_valid_q, first_valid_d;
    logic [POS_W-1:0]   first_pos_q, first_pos_d;

    logic [PAT_MAX-1:0] hist_n;
    logic [LEN_W-1:0]   len_clip;
    logic               pat_eq;
    logic               seen_ok;
    logic               match;

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        pat_d         = pat_q;
        pl_d          = pl_q;
        hist_d        = hist_q;
        seen_d        = seen_q;
        busy_d        = 1'b0;
        ser_bit_d     = 1'b0;
        detected_d    = 1'b0;
        done_d        = 1'b0;
        cfg_err_d     = cfg_err_q;
        match_count_d = match_count_q;
        first_valid_d = first_valid_q;
        first_pos_d   = first_pos_q;

        hist_n   = {hist_q, ser_bit_q};
        len_clip = (frame_len > LEN_W'(FRAME_W)) ? LEN_W'(FRAME_W) : frame_len;

        // Compare only the low pat_len bits of the history against the pattern
        pat_eq = 1'b1;
        for (int i = 0; i < PAT_MAX; i++) begin
            if ((PL_W'(i) < pl_q) && (hist_n[i] != pat_q[i])) begin
                pat_eq = 1'b0;
            end
        end
        seen_ok = ((32'(seen_q) + 32'd1) >= 32'(pl_q));
        match   = (state_q == S_SHIFT) && !cfg_err_q && seen_ok && pat_eq;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    frame_d       = frame_data >> 1;
                    len_d         = len_clip;
                    cnt_d         = '0;
                    pat_d         = pattern;
                    pl_d          = pat_len;
                    hist_d        = '0;
                    seen_d        = '0;
                    cfg_err_d     = (pat_len == '0) || (pat_len > PL_W'(PAT_MAX));
                    match_count_d = '0;
                    first_valid_d = 1'b0;
                    first_pos_d   = '0;
                    if (len_clip == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_SHIFT;
                        busy_d    = 1'b1;
                        ser_bit_d = frame_data[0];
                    end
                end
            end
            S_SHIFT: begin
                hist_d = hist_n[PAT_MAX-2:0];
                seen_d = (seen_q < PL_W'(PAT_MAX)) ? seen_q + PL_W'(1) : seen_q;
                if (match) begin
                    detected_d    = 1'b1;
                    match_count_d = match_count_q + LEN_W'(1);
                    if (!first_valid_q) begin
                        first_valid_d = 1'b1;
                        first_pos_d   = POS_W'(cnt_q);
                    end
`ifdef SEQ_NONOVERLAP_EN
                    hist_d = '0;
                    seen_d = '0;
`endif
                end
                if (cnt_q == len_q - LEN_W'(1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d    = 1'b1;
                    ser_bit_d = frame_q[0];
                    frame_d   = frame_q >> 1;
                    cnt_d     = cnt_q + LEN_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            frame_q       <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            pat_q         <= '0;
            pl_q          <= '0;
            hist_q        <= '0;
            seen_q        <= '0;
            busy_q        <= 1'b0;
            ser_bit_q     <= 1'b0;
            detected_q    <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            match_count_q <= '0;
            first_valid_q <= 1'b0;
            first_pos_q   <= '0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            pat_q         <= pat_d;
            pl_q          <= pl_d;
            hist_q        <= hist_d;
            seen_q        <= seen_d;
            busy_q        <= busy_d;
            ser_bit_q     <= ser_bit_d;
            detected_q    <= detected_d;
            done_q        <= done_d;
            cfg_err_q     <= cfg_err_d;
            match_count_q <= match_count_d;
            first_valid_q <= first_valid_d;
            first_pos_q   <= first_pos_d;
        end
    end

    assign busy        = busy_q;
    assign ser_bit     = ser_bit_q;
    assign detected    = detected_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;
    assign match_count = match_count_q;
    assign first_valid = first_valid_q;
    assign first_pos   = first_pos_q;

endmodule
